// File: rtl/dmem_trace_buffer_pkg.sv
// Shared types and helpers for the data-memory transaction tracer.
package dmem_trace_buffer_pkg;

    // Capture filter modes as driven on the mode input
    typedef enum logic [1:0] {
        TRACE_MODE_OFF = 2'b00,
        TRACE_MODE_WR  = 2'b01,
        TRACE_MODE_RD  = 2'b10,
        TRACE_MODE_ALL = 2'b11
    } trace_mode_e;

    // What the circular buffer does on a given edge
    typedef enum logic [2:0] {
        ACT_IDLE,
        ACT_PUSH,
        ACT_OVERWRITE,
        ACT_DROP,
        ACT_PUSH_POP,
        ACT_POP
    } buf_action_e;

    // True when an access of the given direction passes the mode filter
    function automatic logic mode_match(input logic [1:0] mode, input logic we);
        logic m;
        m = 1'b0;
        case (mode)
            TRACE_MODE_WR:  m = we;
            TRACE_MODE_RD:  m = ~we;
            TRACE_MODE_ALL: m = 1'b1;
            default:        m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_trace_buffer_ram.sv
// Trace entry storage: one synchronous write port, one asynchronous read port.
module dmem_trace_buffer_ram
    import dmem_trace_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 81
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store a captured entry; contents are deliberately never cleared
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_trace_buffer.sv
// Snoops the CPU data-memory port, filters and timestamps accesses and keeps
// them in a circular buffer that a consumer drains over valid/ready.
module dmem_trace_buffer
    import dmem_trace_buffer_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int TS_W        = 16,
    parameter int CYCLE_LIMIT = 100
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mon_valid,
    input  logic [ADDR_W-1:0]        mon_addr,
    input  logic                     mon_write_en,
    input  logic [DATA_W-1:0]        mon_write_data,
    input  logic [DATA_W-1:0]        mon_read_data,
    input  logic [1:0]               mode,
    input  logic                     wrap_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TS_W-1:0]          out_ts,
    output logic                     out_we,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     done
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = TS_W + 1 + ADDR_W + DATA_W;
    localparam logic [TS_W-1:0] LIMIT_TS = TS_W'((CYCLE_LIMIT > 0) ? (CYCLE_LIMIT - 1) : 0);

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic [TS_W-1:0]    ts;
    logic               done_q;
    logic               overflow_q;
    logic               full;
    logic               cap;
    logic               pop;
    logic               limit_hit;
    logic               ram_we;
    logic [DATA_W-1:0]  cap_data;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    buf_action_e        act;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign cap       = mon_valid & mode_match(mode, mon_write_en) & ~done_q;
    assign limit_hit = (CYCLE_LIMIT > 0) && (ts == LIMIT_TS);
    assign cap_data  = mon_write_en ? mon_write_data : mon_read_data;
    assign wr_entry  = {ts, mon_write_en, mon_addr, cap_data};

    // Free-running saturating timestamp plus the sticky watchdog flag
    always_ff @(posedge clk) begin
        if (reset) begin
            ts     <= '0;
            done_q <= 1'b0;
        end else begin
            if (ts != '1) begin
                ts <= ts + TS_W'(1);
            end
            if (limit_hit) begin
                done_q <= 1'b1;
            end
        end
    end

    // Decide how capture and pop combine on this edge; a pop frees a slot so it wins over overflow
    always_comb begin
        act = ACT_IDLE;
        if (cap && pop) begin
            act = ACT_PUSH_POP;
        end else if (cap && !full) begin
            act = ACT_PUSH;
        end else if (cap && wrap_en) begin
            act = ACT_OVERWRITE;
        end else if (cap) begin
            act = ACT_DROP;
        end else if (pop) begin
            act = ACT_POP;
        end
    end

    assign ram_we = ~reset & ((act == ACT_PUSH) | (act == ACT_OVERWRITE) | (act == ACT_PUSH_POP));

    // Pointer, occupancy and sticky overflow bookkeeping; reset discards any in-flight pop
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (act)
                ACT_PUSH: begin
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                    count_q <= count_q + CNT_W'(1);
                end
                ACT_OVERWRITE: begin
                    wr_ptr     <= wr_ptr + PTR_W'(1);
                    rd_ptr     <= rd_ptr + PTR_W'(1);
                    overflow_q <= 1'b1;
                end
                ACT_DROP: begin
                    overflow_q <= 1'b1;
                end
                ACT_PUSH_POP: begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                ACT_POP: begin
                    rd_ptr  <= rd_ptr + PTR_W'(1);
                    count_q <= count_q - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    dmem_trace_buffer_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    assign out_data = rd_entry[DATA_W-1:0];
    assign out_addr = rd_entry[DATA_W +: ADDR_W];
    assign out_we   = rd_entry[DATA_W + ADDR_W];
    assign out_ts   = rd_entry[ENTRY_W-1 -: TS_W];
    assign count    = count_q;
    assign overflow = overflow_q;
    assign done     = done_q;

endmodule

// File: tb/tb_dmem_trace_buffer.sv
// Bench for the data-memory tracer: directed scenarios followed by random
// traffic, all compared against a queue-based model of the trace buffer.
module tb_dmem_trace_buffer;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int DEPTH       = 16;
    localparam int TS_W        = 16;
    localparam int CYCLE_LIMIT = 100;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              mon_valid = 1'b0;
    logic [ADDR_W-1:0] mon_addr = '0;
    logic              mon_write_en = 1'b0;
    logic [DATA_W-1:0] mon_write_data = '0;
    logic [DATA_W-1:0] mon_read_data = '0;
    logic [1:0]        mode = 2'b11;
    logic              wrap_en = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [TS_W-1:0]   out_ts;
    logic              out_we;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic [4:0]        count;
    logic              overflow;
    logic              done;

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    dmem_trace_buffer #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .TS_W        (TS_W),
        .CYCLE_LIMIT (CYCLE_LIMIT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mon_valid      (mon_valid),
        .mon_addr       (mon_addr),
        .mon_write_en   (mon_write_en),
        .mon_write_data (mon_write_data),
        .mon_read_data  (mon_read_data),
        .mode           (mode),
        .wrap_en        (wrap_en),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ts         (out_ts),
        .out_we         (out_we),
        .out_addr       (out_addr),
        .out_data       (out_data),
        .count          (count),
        .overflow       (overflow),
        .done           (done)
    );

    typedef struct {
        int unsigned ts;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    entry_t      model_q[$];
    int unsigned m_cycles;
    logic        m_done;
    logic        m_ovf;
    int          checks = 0;
    int          errors = 0;
    logic [1:0]  cur_mode = 2'b11;
    logic        cur_wrap = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: a bounded FIFO of entries, cycles counted since reset
    task automatic model_step(input logic rst, v, w, input logic [31:0] a, wd, rd,
                              input logic [1:0] md, input logic wr, rdy);
        entry_t e;
        logic   wanted;
        logic   cap;
        logic   pop;
        if (rst) begin
            model_q.delete();
            m_cycles = 0;
            m_done   = 1'b0;
            m_ovf    = 1'b0;
            return;
        end
        wanted = (md == 2'b11) || (md == 2'b01 && w) || (md == 2'b10 && !w);
        cap    = v && wanted && !m_done;
        pop    = rdy && (model_q.size() != 0);
        e.ts   = m_cycles;
        e.we   = w;
        e.addr = a;
        e.data = w ? wd : rd;
        if (pop) void'(model_q.pop_front());
        if (cap) begin
            if (model_q.size() < DEPTH) begin
                model_q.push_back(e);
            end else begin
                m_ovf = 1'b1;
                if (wr) begin
                    void'(model_q.pop_front());
                    model_q.push_back(e);
                end
            end
        end
        if (m_cycles + 1 >= CYCLE_LIMIT) m_done = 1'b1;
        if (m_cycles < (1 << TS_W) - 1) m_cycles++;
    endtask

    task automatic check_model();
        checkOutput("count", 64'(count), 64'(model_q.size()));
        checkOutput("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
        checkOutput("overflow", 64'(overflow), 64'(m_ovf));
        checkOutput("done", 64'(done), 64'(m_done));
        if (model_q.size() != 0) begin
            checkOutput("out_ts", 64'(out_ts), 64'(model_q[0].ts));
            checkOutput("out_we", 64'(out_we), 64'(model_q[0].we));
            checkOutput("out_addr", 64'(out_addr), 64'(model_q[0].addr));
            checkOutput("out_data", 64'(out_data), 64'(model_q[0].data));
        end
    endtask

    // One clock: drive inputs at the falling edge, advance the model, check after the next falling edge
    task automatic applyStimulus(input logic rst, v, w, input logic [31:0] a, wd, rd,
                                 input logic [1:0] md, input logic wr, rdy);
        reset          = rst;
        mon_valid      = v;
        mon_write_en   = w;
        mon_addr       = a;
        mon_write_data = wd;
        mon_read_data  = rd;
        mode           = md;
        wrap_en        = wr;
        out_ready      = rdy;
        model_step(rst, v, w, a, wd, rd, md, wr, rdy);
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, cur_mode, cur_wrap, 1'b0);
    endtask

    task automatic do_idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, cur_mode, cur_wrap, 1'b0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic rdy);
        applyStimulus(1'b0, 1'b1, 1'b1, a, d, 32'hDEAD_0000, cur_mode, cur_wrap, rdy);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d);
        applyStimulus(1'b0, 1'b1, 1'b0, a, 32'hBEEF_0000, d, cur_mode, cur_wrap, 1'b0);
    endtask

    task automatic do_pop();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, cur_mode, cur_wrap, 1'b1);
    endtask

    initial begin
        @(negedge clk);

        $display("[TB] reset state and three timestamped writes");
        cur_mode = 2'b11;
        cur_wrap = 1'b0;
        do_reset();
        checkOutput("reset_count", 64'(count), 64'd0);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_overflow", 64'(overflow), 64'd0);
        for (int i = 0; i < 11; i++) do_idle();
        do_write(32'd4, 32'd1, 1'b0);
        do_write(32'd8, 32'd2, 1'b0);
        do_write(32'd12, 32'd3, 1'b0);
        checkOutput("t1_count", 64'(count), 64'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t1_ts", 64'(out_ts), 64'(11 + i));
            checkOutput("t1_we", 64'(out_we), 64'd1);
            checkOutput("t1_addr", 64'(out_addr), 64'(4 + 4 * i));
            checkOutput("t1_data", 64'(out_data), 64'(1 + i));
            do_pop();
        end
        checkOutput("t1_empty", 64'(out_valid), 64'd0);

        $display("[TB] write-only filter");
        cur_mode = 2'b01;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) do_write(32'(16 * i), 32'(100 + i), 1'b0);
            else            do_read(32'(16 * i), 32'(200 + i));
        end
        checkOutput("t2_count", 64'(count), 64'd4);
        checkOutput("t2_head_we", 64'(out_we), 64'd1);

        $display("[TB] full buffer without wrap drops new entries");
        cur_mode = 2'b11;
        cur_wrap = 1'b0;
        do_reset();
        for (int i = 0; i < 20; i++) do_write(32'(4 * i), 32'(i), 1'b0);
        checkOutput("t3_count", 64'(count), 64'd16);
        checkOutput("t3_overflow", 64'(overflow), 64'd1);
        for (int i = 0; i < 16; i++) begin
            checkOutput("t3_data", 64'(out_data), 64'(i));
            do_pop();
        end

        $display("[TB] full buffer with wrap overwrites oldest");
        cur_wrap = 1'b1;
        do_reset();
        for (int i = 0; i < 20; i++) do_write(32'(4 * i), 32'(i), 1'b0);
        checkOutput("t4_count", 64'(count), 64'd16);
        checkOutput("t4_overflow", 64'(overflow), 64'd1);
        for (int i = 0; i < 16; i++) begin
            checkOutput("t4_data", 64'(out_data), 64'(4 + i));
            do_pop();
        end

        $display("[TB] capture and pop together on a full buffer");
        cur_wrap = 1'b0;
        do_reset();
        for (int i = 0; i < 16; i++) do_write(32'(4 * i), 32'(i), 1'b0);
        do_write(32'h100, 32'd16, 1'b1);
        checkOutput("t5_count", 64'(count), 64'd16);
        checkOutput("t5_overflow", 64'(overflow), 64'd0);
        checkOutput("t5_head", 64'(out_data), 64'd1);

        $display("[TB] watchdog freezes capture, reset clears everything");
        cur_wrap = 1'b1;
        do_reset();
        for (int i = 0; i < 99; i++) do_write(32'(i), 32'(i), 1'b0);
        checkOutput("t6_done_early", 64'(done), 64'd0);
        do_write(32'd99, 32'd99, 1'b0);
        checkOutput("t6_done", 64'(done), 64'd1);
        for (int i = 0; i < 11; i++) do_write(32'h500, 32'h500, 1'b1);
        checkOutput("t6_count", 64'(count), 64'd5);
        checkOutput("t6_head_ts", 64'(out_ts), 64'd95);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h40, 32'h41, 32'h0, cur_mode, cur_wrap, 1'b1);
        checkOutput("t6_rst_count", 64'(count), 64'd0);
        checkOutput("t6_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("t6_rst_done", 64'(done), 64'd0);
        do_write(32'h44, 32'h45, 1'b0);
        checkOutput("t6_rst_ts", 64'(out_ts), 64'd0);

        $display("[TB] random traffic");
        for (int r = 0; r < 6; r++) begin
            cur_mode = 2'($urandom_range(0, 3));
            do_reset();
            for (int k = 0; k < 130; k++) begin
                applyStimulus($urandom_range(0, 59) == 0,
                              $urandom_range(0, 9) < 7,
                              1'($urandom),
                              $urandom, $urandom, $urandom,
                              ($urandom_range(0, 15) == 0) ? 2'($urandom) : cur_mode,
                              1'($urandom),
                              $urandom_range(0, 9) < 4);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
